// File: rtl/ptos_pkg.sv
// ptos_pkg: shared constants and helpers for the lane serializer.
//   K28_5          - comma symbol used as the default idle symbol
//   ptos_slot_len  - bits per slot; one extra parity bit when the build
//                    defines PTOS_PARITY_EN
//   ptos_first_bit - index of the bit that leaves the shifter first
package ptos_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;

    function automatic int ptos_slot_len(input int data_w);
`ifdef PTOS_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

    function automatic int ptos_first_bit(input int data_w, input bit msb_first);
        return msb_first ? data_w - 1 : 0;
    endfunction

endpackage

// File: rtl/ptos_lane_shifter.sv
// ptos_lane_shifter: one serial lane. Loads a DATA_W symbol at each slot
// boundary and shifts it out one bit per clk in the configured order.
// With PTOS_PARITY_EN defined, an even-parity bit of the loaded symbol is
// presented while par_sel is high (the last bit of the slot).
// Ports:
//   clk, reset  - bit clock, asynchronous active-high reset
//   load        - capture sym on this edge (slot boundary)
//   par_sel     - (PTOS_PARITY_EN only) select the parity bit for output
//   sym         - symbol to load (data byte or idle symbol)
//   out_s       - serial output bit
module ptos_lane_shifter
    import ptos_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] IDLE_SYM  = DATA_W'(K28_5),
    parameter bit                MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
`ifdef PTOS_PARITY_EN
    input  logic              par_sel,
`endif
    input  logic [DATA_W-1:0] sym,
    output logic              out_s
);

    localparam int FIRST = ptos_first_bit(DATA_W, MSB_FIRST);

    logic [DATA_W-1:0] shift_reg;

    // Shift toward the output end so the next bit always sits at FIRST.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= IDLE_SYM;
        end else if (load) begin
            shift_reg <= sym;
        end else if (MSB_FIRST) begin
            shift_reg <= shift_reg << 1;
        end else begin
            shift_reg <= shift_reg >> 1;
        end
    end

`ifdef PTOS_PARITY_EN
    logic par_reg;

    // Parity is latched at load time so it survives the data being shifted out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_reg <= ^IDLE_SYM;
        end else if (load) begin
            par_reg <= ^sym;
        end
    end

    assign out_s = par_sel ? par_reg : shift_reg[FIRST];
`else
    assign out_s = shift_reg[FIRST];
`endif

endmodule

// File: rtl/ptos_lane_serializer.sv
// ptos_lane_serializer: multi-lane parallel-to-serial converter.
// Accepts LANES*DATA_W-bit words over valid/ready into a one-deep hold
// register and emits them as fixed-length slots, one bit per lane per clk.
// Idle slots carry IDLE_SYM; the first SYNC_SLOTS slots after reset are
// always idle. Build option: define PTOS_PARITY_EN to append one even-parity
// bit per lane to every slot.
// Ports:
//   clk, reset  - bit clock, asynchronous active-high reset
//   in_data     - parallel word, lane i = in_data[i*DATA_W +: DATA_W]
//   in_valid    - word present
//   in_ready    - hold register empty; transfer when in_valid & in_ready
//   out_s       - serial bit per lane
//   out_valid   - current slot carries accepted data
//   out_sof     - first bit of each slot
module ptos_lane_serializer
    import ptos_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                LANES      = 1,
    parameter logic [DATA_W-1:0] IDLE_SYM   = DATA_W'(K28_5),
    parameter int                SYNC_SLOTS = 4,
    parameter bit                MSB_FIRST  = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [LANES-1:0]        out_s,
    output logic                    out_valid,
    output logic                    out_sof
);

    localparam int SLOT_LEN = ptos_slot_len(DATA_W);
    localparam int CNT_W    = $clog2(SLOT_LEN + 1);
    localparam int SYNC_W   = $clog2(SYNC_SLOTS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SLOT_LEN - 1);

    logic [CNT_W-1:0]        slot_cnt_reg;
    logic [SYNC_W-1:0]       sync_cnt_reg;
    logic                    hold_valid_reg;
    logic [LANES*DATA_W-1:0] hold_data_reg;
    logic                    out_valid_reg;

    logic slot_end;
    logic sync_done;
    logic load_data;
    logic accept;

    assign slot_end  = (slot_cnt_reg == LAST_BIT);
    // sync_cnt_reg counts idle slots still owed, including the current one;
    // data may be loaded at the end of the last owed slot.
    assign sync_done = (sync_cnt_reg <= SYNC_W'(1));
    assign load_data = slot_end & sync_done & hold_valid_reg;
    assign accept    = in_valid & ~hold_valid_reg;

    assign in_ready  = ~hold_valid_reg;
    assign out_valid = out_valid_reg;
    assign out_sof   = (slot_cnt_reg == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt_reg <= '0;
        end else if (slot_end) begin
            slot_cnt_reg <= '0;
        end else begin
            slot_cnt_reg <= slot_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_cnt_reg <= SYNC_W'(SYNC_SLOTS);
        end else if (slot_end && (sync_cnt_reg != '0)) begin
            sync_cnt_reg <= sync_cnt_reg - SYNC_W'(1);
        end
    end

    // Accept and load are mutually exclusive: accept needs an empty hold,
    // load needs a full one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
        end else if (accept) begin
            hold_valid_reg <= 1'b1;
            hold_data_reg  <= in_data;
        end else if (load_data) begin
            hold_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
        end else if (slot_end) begin
            out_valid_reg <= load_data;
        end
    end

`ifdef PTOS_PARITY_EN
    logic par_sel;
    assign par_sel = (slot_cnt_reg == CNT_W'(DATA_W));
`endif

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DATA_W-1:0] lane_sym;

            assign lane_sym = load_data ? hold_data_reg[gi*DATA_W +: DATA_W] : IDLE_SYM;

            ptos_lane_shifter #(
                .DATA_W    (DATA_W),
                .IDLE_SYM  (IDLE_SYM),
                .MSB_FIRST (MSB_FIRST)
            ) u_shifter (
                .clk     (clk),
                .reset   (reset),
                .load    (slot_end),
`ifdef PTOS_PARITY_EN
                .par_sel (par_sel),
`endif
                .sym     (lane_sym),
                .out_s   (out_s[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_ptos_lane_serializer.sv
module tb_ptos_lane_serializer;

    localparam int DATA_W = 8;
    localparam int LANES  = 2;
    localparam int SYNC   = 4;
`ifdef PTOS_PARITY_EN
    localparam int SLOT_LEN = DATA_W + 1;
`else
    localparam int SLOT_LEN = DATA_W;
`endif
    localparam logic [7:0] IDLE = 8'hBC;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [LANES*DATA_W-1:0] in_data = '0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [LANES-1:0]        out_s;
    logic                    out_valid;
    logic                    out_sof;

    ptos_lane_serializer #(
        .DATA_W     (DATA_W),
        .LANES      (LANES),
        .IDLE_SYM   (IDLE),
        .SYNC_SLOTS (SYNC),
        .MSB_FIRST  (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_s     (out_s),
        .out_valid (out_valid),
        .out_sof   (out_sof)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: cycle number since reset release, a queue of accepted
    // words, and the word (if any) assigned to the current slot.
    int                      cyc;
    logic [LANES*DATA_W-1:0] q[$];
    logic [LANES*DATA_W-1:0] cur_word;
    bit                      cur_valid;

    task automatic model_reset();
        cyc       = 0;
        q.delete();
        cur_word  = '0;
        cur_valid = 1'b0;
    endtask

    function automatic logic exp_bit(input int lane);
        logic [7:0] sym;
        int b;
        sym = cur_valid ? cur_word[lane*DATA_W +: DATA_W] : IDLE;
        b = cyc % SLOT_LEN;
        if (b < DATA_W) return sym[DATA_W-1-b];
        return ^sym;
    endfunction

    task automatic check_cycle();
        logic [LANES-1:0] e;
        for (int l = 0; l < LANES; l++) e[l] = exp_bit(l);
        check("out_s", 32'(out_s), 32'(e));
        check("out_valid", 32'(out_valid), 32'(cur_valid));
        check("out_sof", 32'(out_sof), 32'((cyc % SLOT_LEN) == 0));
        check("in_ready", 32'(in_ready), 32'(q.size() == 0));
    endtask

    task automatic model_edge();
        int  b;
        int  k;
        bit  ready_pre;
        b = cyc % SLOT_LEN;
        k = cyc / SLOT_LEN;
        ready_pre = (q.size() == 0);
        if (b == SLOT_LEN - 1) begin
            if ((k >= SYNC - 1) && (q.size() > 0)) begin
                cur_word  = q.pop_front();
                cur_valid = 1'b1;
                $display("slot %0d: data word=%h", k + 1, cur_word);
            end else begin
                cur_valid = 1'b0;
            end
        end
        if (in_valid && ready_pre) begin
            q.push_back(in_data);
            $display("cycle %0d: accept word=%h", cyc, in_data);
        end
        cyc++;
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic run_cycle(input int pct);
        check_cycle();
        in_data  = LANES*DATA_W'($urandom);
        in_valid = ($urandom_range(99) < pct);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_s"}, 32'(out_s), 32'({LANES{IDLE[DATA_W-1]}}));
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_sof"}, 32'(out_sof), 32'd1);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        bit found;
        model_reset();
        #12;
        check_reset_values("rst");

        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Sync idle slots, then random traffic at several load levels.
        for (int i = 0; i < 6 * SLOT_LEN; i++) run_cycle(0);
        for (int i = 0; i < 400; i++) run_cycle(100);
        for (int i = 0; i < 800; i++) run_cycle(50);
        for (int i = 0; i < 600; i++) run_cycle(15);
        for (int i = 0; i < 300; i++) run_cycle(100);

        // Reach bit 3 of a data slot with another word held, then reset mid-cycle.
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cur_valid && ((cyc % SLOT_LEN) == 3) && (q.size() == 1)) begin
                found = 1'b1;
                break;
            end
            run_cycle(100);
        end
        check("rst_point_found", 32'(found), 32'd1);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(posedge clk);
        @(negedge clk);
        check_reset_values("rst_held");
        reset = 1'b0;
        model_reset();

        for (int i = 0; i < 6 * SLOT_LEN; i++) run_cycle(0);
        for (int i = 0; i < 300; i++) run_cycle(70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
